uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one uart_sm_tx byte engine among NUM_REQ requesters (core MMIO, debug monitor, trace, etc.). It captures one requester's byte and issues a single-cycle send pulse to the engine. It holds the byte stable for the whole frame, waits for the engine's byte_end, then reports completion to the owning requester. Sits between the bus-side peripherals and uart_sm_tx; shares clk/reset with the engine.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte engine among NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN to replace round robin with fixed priority (requester 0 highest).
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic                 busy_o,
  output logic                 tx_send_pulse_o,
  output logic [7:0]           tx_byte_o,
  input  logic                 tx_byte_end_i,
  output logic [CNT_W-1:0]     sent_count_o
);

  localparam int unsigned IdxW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StBusy  = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IdxW-1:0]    winner;
  logic [7:0]         winner_data;
  logic               take;
  logic               fin;

`ifdef UART_ARB_FIXED_PRIO_EN
  logic prio_found;

  always_comb begin
    winner     = '0;
    prio_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!prio_found && req_i[i]) begin
        winner     = IdxW'(i);
        prio_found = 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] last_q, last_d;
  logic            rr_found;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Search last+1, last+2, ... with wrap; last itself is checked last.
  always_comb begin
    winner   = last_q;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[IdxW-1:0];
      if (!rr_found && req_i[cand_idx]) begin
        winner   = cand_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign last_d = take ? winner : last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IdxW'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    winner_data = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IdxW'(i)) begin
        winner_data = req_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    fin       = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          take      = 1'b1;
          owner_d   = winner;
          tx_byte_d = winner_data;
          state_d   = StStart;
        end
      end
      StStart: state_d = StBusy;
      StBusy: begin
        if (tx_byte_end_i) begin
          fin     = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StGap;
        end
      end
      // Engine cannot take a send pulse in the cycle it raises byte_end.
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_d = '0;
    done_d  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_d[i] = take && (winner == IdxW'(i));
      done_d[i]  = fin && (owner_q == IdxW'(i));
    end
    busy_d  = (state_d != StIdle);
    pulse_d = (state_d == StStart);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      tx_byte_q <= 8'h00;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tx_byte_q <= tx_byte_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign busy_o          = busy_q;
  assign tx_send_pulse_o = pulse_q;
  assign tx_byte_o       = tx_byte_q;
  assign sent_count_o    = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural 32 clk/bit byte engine.
module tb_uart_tx_arbiter;

  localparam int unsigned BitClks   = 32;
  localparam int unsigned FrameClks = 10 * BitClks;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_byte_end;

  logic [3:0]  grant, done, grant_s, done_s;
  logic        busy, busy_s, pulse, pulse_s;
  logic [7:0]  tx_byte, tx_byte_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req),
    .req_data_i      (req_data),
    .grant_o         (grant),
    .done_o          (done),
    .busy_o          (busy),
    .tx_send_pulse_o (pulse),
    .tx_byte_o       (tx_byte),
    .tx_byte_end_i   (tx_byte_end),
    .sent_count_o    (cnt)
  );

  // Narrow-counter twin so counter wrap is reached in a short run.
  uart_tx_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut_s (
    .clk             (clk),
    .reset           (reset),
    .req_i           (req),
    .req_data_i      (req_data),
    .grant_o         (grant_s),
    .done_o          (done_s),
    .busy_o          (busy_s),
    .tx_send_pulse_o (pulse_s),
    .tx_byte_o       (tx_byte_s),
    .tx_byte_end_i   (tx_byte_end),
    .sent_count_o    (cnt_s)
  );

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: written only here.
  logic [9:0] rx_last = '0;
  logic [9:0] frame_sh;
  int         rx_n = 0;
  int         eng_cnt;
  bit         eng_active;
  int         spur_idle_req = 0, spur_idle_ack = 0;
  int         spur_start_req = 0, spur_start_ack = 0;

  initial begin
    tx_byte_end = 1'b0;
    eng_active  = 1'b0;
    eng_cnt     = 0;
    frame_sh    = '0;
    forever begin
      @(negedge clk);
      tx_byte_end = 1'b0;
      if (reset === 1'b1) begin
        eng_active = 1'b0;
      end else if (eng_active) begin
        eng_cnt++;
        if (((eng_cnt - 1) % BitClks) == BitClks / 2) begin
          int b;
          b = (eng_cnt - 1) / BitClks;
          if (b == 0) frame_sh[0] = 1'b0;
          else if (b == 9) frame_sh[9] = 1'b1;
          else frame_sh[b] = tx_byte[b-1];
        end
        if (eng_cnt == FrameClks) begin
          tx_byte_end = 1'b1;
          rx_last     = frame_sh;
          rx_n++;
          eng_active  = 1'b0;
        end
      end else if (pulse === 1'b1) begin
        eng_active = 1'b1;
        eng_cnt    = 0;
        frame_sh   = '0;
        if (spur_start_req != spur_start_ack) begin
          tx_byte_end = 1'b1;
          spur_start_ack++;
        end
      end else if (spur_idle_req != spur_idle_ack) begin
        tx_byte_end = 1'b1;
        spur_idle_ack++;
      end
    end
  end

  typedef struct {
    int         owner;
    logic [7:0] b;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_rr;
    int          exp_fp;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_m = '0;
  int          rx_base;
  int          grant_cyc;

  task automatic chk(input string tag, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h, want %0h", tag, what, act, exp);
    end
  endtask

  task automatic push_exp(input int owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.b     = data[8*owner +: 8];
    exp_q.push_back(e);
  endtask

  // Grant must appear exactly one cycle after req is sampled in IDLE.
  task automatic take_grant(input string tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk(tag, "scoreboard empty", 32'd1, 32'd0);
      return;
    end
    cur = exp_q.pop_front();
    chk(tag, "grant", grant, 32'(4'b0001 << cur.owner));
    chk(tag, "send_pulse", pulse, 1);
    chk(tag, "tx_byte", tx_byte, cur.b);
    chk(tag, "busy", busy, 1);
    chk(tag, "grant_s", grant_s, 32'(4'b0001 << cur.owner));
    chk(tag, "pulse_s/tx_byte_s", {pulse_s, tx_byte_s}, {1'b1, cur.b});
    rx_base   = rx_n;
    grant_cyc = cyc;
  endtask

  task automatic finish_frame(input string tag);
    bit got    = 1'b0;
    bit stable = 1'b1;
    for (int i = 0; i < int'(FrameClks) + 8 && !got; i++) begin
      @(negedge clk);
      if (done !== 4'b0000) got = 1'b1;
      else if (tx_byte !== cur.b) stable = 1'b0;
    end
    chk(tag, "done seen", got, 1);
    cnt_m = cnt_m + 16'd1;
    chk(tag, "done latency", cyc - grant_cyc, FrameClks + 1);
    chk(tag, "done", done, 32'(4'b0001 << cur.owner));
    chk(tag, "done_s", done_s, 32'(4'b0001 << cur.owner));
    chk(tag, "sent_count", cnt, cnt_m);
    chk(tag, "sent_count_s", cnt_s, cnt_m[3:0]);
    chk(tag, "tx_byte stable", stable, 1);
    chk(tag, "tx_byte at done", tx_byte, cur.b);
    chk(tag, "frames", rx_n - rx_base, 1);
    chk(tag, "serial frame", rx_last, {1'b1, cur.b, 1'b0});
    chk(tag, "busy in gap", busy, 1);
    @(negedge clk);
    chk(tag, "idle after gap", {busy, busy_s, done}, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   own;
    int   prev_cyc;
    bit   bad_seen;

    vecs[0] = '{4'b0010, 32'h0000A500, 1, 1};
    vecs[1] = '{4'b1001, 32'h33000011, 3, 0};
    vecs[2] = '{4'b0101, 32'h00220020, 0, 0};
    vecs[3] = '{4'b0101, 32'h00B200B0, 2, 0};
    vecs[4] = '{4'b1000, 32'hC3000000, 3, 3};
    vecs[5] = '{4'b1111, 32'h43424140, 0, 0};
    vecs[6] = '{4'b0110, 32'h00626100, 1, 1};
    vecs[7] = '{4'b0011, 32'h00008180, 0, 0};

    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset", "grant", grant, 0);
    chk("reset", "done", done, 0);
    chk("reset", "busy", busy, 0);
    chk("reset", "send_pulse", pulse, 0);
    chk("reset", "tx_byte", tx_byte, 0);
    chk("reset", "sent_count", cnt, 0);
    chk("reset", "sent_count_s", cnt_s, 0);

    // Table-driven single requests.
    for (int i = 0; i < 8; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      own = vecs[i].exp_fp;
`else
      own = vecs[i].exp_rr;
`endif
      req      = vecs[i].req;
      req_data = vecs[i].data;
      push_exp(own, vecs[i].data);
      take_grant($sformatf("vec%0d", i));
      req = 4'b0000;
      finish_frame($sformatf("vec%0d", i));
      if (i == 0) chk("vec0", "A5 line bits", rx_last, 10'h34A);
    end

    // Data changes during BUSY; held req becomes a second byte with new data.
    req      = 4'b0100;
    req_data = 32'h00550000;
    push_exp(2, req_data);
    take_grant("hold1");
    repeat (50) @(negedge clk);
    req_data = 32'h00FF0000;
    push_exp(2, req_data);
    finish_frame("hold1");
    take_grant("hold2");
    req = 4'b0000;
    finish_frame("hold2");

    // Spurious byte_end in IDLE.
    spur_idle_req++;
    bad_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 4'b0000 || busy !== 1'b0) bad_seen = 1'b1;
    end
    chk("spur_idle", "done/busy activity", bad_seen, 0);
    chk("spur_idle", "sent_count", cnt, cnt_m);

    // Spurious byte_end during START must not end the frame.
    spur_start_req++;
    req      = 4'b1000;
    req_data = 32'h3C000000;
    push_exp(3, req_data);
    take_grant("spur_start");
    req = 4'b0000;
    finish_frame("spur_start");

    // Reset 100 cycles into a frame.
    req      = 4'b0001;
    req_data = 32'h0000005A;
    push_exp(0, req_data);
    take_grant("abort");
    req = 4'b0000;
    bad_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (done !== 4'b0000) bad_seen = 1'b1;
    end
    chk("abort", "early done", bad_seen, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort", "busy/pulse/grant/done", {busy, pulse, grant, done}, 0);
    chk("abort", "tx_byte", tx_byte, 0);
    chk("abort", "sent_count", {cnt_s, cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt_m = '0;
    bad_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 4'b0000) bad_seen = 1'b1;
    end
    chk("abort", "done after reset", bad_seen, 0);
    req      = 4'b0001;
    req_data = 32'h0000000F;
    push_exp(0, req_data);
    take_grant("post_reset");
    req = 4'b0000;
    finish_frame("post_reset");

    // Fresh reset, then all requesters held high.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_m = '0;
    req      = 4'b1111;
    req_data = 32'h13121110;
    prev_cyc = 0;
    for (int f = 0; f < 20; f++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      own = 0;
`else
      own = f % 4;
`endif
      push_exp(own, req_data);
      take_grant($sformatf("rr%0d", f));
      if (f > 0) chk($sformatf("rr%0d", f), "pulse spacing", grant_cyc - prev_cyc, FrameClks + 3);
      prev_cyc = grant_cyc;
      finish_frame($sformatf("rr%0d", f));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("end", "grant/busy", {grant, busy, pulse}, 0);
    chk("end", "sent_count", cnt, 20);
    chk("end", "sent_count_s wrapped", cnt_s, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
